uart_rx: RTL

- Asynchronous serial receiver (8N1) that deserialises the external RX line into bytes.
- Presents each byte on an AXI4-Stream master port that feeds the write side of the byte FIFO in the UART/peripheral path.
- Samples at mid-bit using a clock-divider counter.
- Reports framing errors and overruns as single-cycle pulses for the status register.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// AXI4-Stream style byte channel carrying received bytes towards the FIFO.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling via a clock-divider
// counter, one-deep output register on a stream master, framing/overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      rxd,
  uart_rx_if.master out,
  output logic      frame_err,
  output logic      overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  stop_ok, stop_bad;
  logic                  handshake;

  assign rx_s = sync_q[1];

  // Frame sequencer: detect start edge, sample each bit at its centre, check the stop bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;  // glitch, not a real start bit
          end else begin
            idx_d   = '0;
            state_d = StData;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Wait out a held-low line so it cannot produce a stream of bogus frames.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: load on a good stop bit when free, otherwise flag overrun.
  always_comb begin
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    handshake   = tvalid_q & out.tready;
    if (stop_ok) begin
      if (!tvalid_q || handshake) begin
        tvalid_d = 1'b1;
        tdata_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out.tdata  = tdata_q;
  assign out.tvalid = tvalid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
